// File: rtl/display_pkg.sv
// Shared constants and state encoding for the SPI display receiver.
package display_pkg;

    localparam int FRAME_BITS = 16;
    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

endpackage

// File: rtl/spi_display_receiver_if.sv
// SPI pin bundle between the display driver (master) and the receiver (slave).
interface spi_display_receiver_if;
    logic spi_mosi;
    logic spi_cs;
    logic spi_sck;

    modport master (output spi_mosi, output spi_cs, output spi_sck);
    modport slave  (input spi_mosi, input spi_cs, input spi_sck);
endinterface

// File: rtl/spi_input_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, plus rise/fall detection.
module spi_input_sync #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic res,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Synchronizer chain and one history stage, reset to the pin's idle level
    always_ff @(posedge clk) begin
        if (!res) begin
            sync_q <= {STAGES{IDLE_LVL}};
            hist_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_display_receiver.sv
// Oversampling SPI frame receiver keeping a shadow copy of the MAX7219-style register file.
module spi_display_receiver
    import display_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         res,
    spi_display_receiver_if.slave        spi,
    output logic                         frame_valid,
    output logic [3:0]                   frame_addr,
    output logic [7:0]                   frame_data,
    output logic                         frame_err,
    input  logic [2:0]                   rd_sel,
    output logic [7:0]                   rd_data,
    output logic [7:0]                   decode_mode,
    output logic [3:0]                   intensity,
    output logic [2:0]                   scan_limit,
    output logic                         shutdown_n,
    output logic                         display_test
);

    logic cs_lvl_s, cs_rise_s, cs_fall_s;
    logic sck_lvl_s, sck_rise_s, sck_fall_s;
    logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;

    spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_cs (
        .clk(clk), .res(res), .din_i(spi.spi_cs),
        .level_o(cs_lvl_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s));
    spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_sck (
        .clk(clk), .res(res), .din_i(spi.spi_sck),
        .level_o(sck_lvl_s), .rise_o(sck_rise_s), .fall_o(sck_fall_s));
    spi_input_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_mosi (
        .clk(clk), .res(res), .din_i(spi.spi_mosi),
        .level_o(mosi_lvl_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s));

    state_e                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d, cnt_eff_s;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    err_d;
    logic                    frame_valid_q, frame_err_q;
    logic [3:0]              frame_addr_q;
    logic [7:0]              frame_data_q;
    logic [7:0]              digit_q [8];
    logic [7:0]              decode_q;
    logic [3:0]              intensity_q;
    logic [2:0]              scan_q;
    logic                    shutdown_q, test_q;
    logic [3:0]              wr_addr_s;
    logic [7:0]              wr_data_s;

    // FSM state, bit counter and shift register
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Next state; a bit arriving with the Cs rise is counted before the length check
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        err_d     = 1'b0;
        cnt_eff_s = cnt_q;
        case (state_q)
            IDLE: begin
                if (cs_fall_s) begin
                    state_d = SHIFT;
                    cnt_d   = 5'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (sck_rise_s) begin
                    shift_d   = {shift_q[FRAME_BITS-2:0], mosi_lvl_s};
                    cnt_eff_s = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
                end else begin
                    cnt_eff_s = cnt_q;
                end
                cnt_d = cnt_eff_s;
                if (cs_rise_s) begin
                    if (cnt_eff_s >= FRAME_CNT) begin
                        state_d = LATCH;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wr_addr_s = shift_q[11:8];
    assign wr_data_s = shift_q[7:0];

    // Frame outputs and register-file write, all landing on the edge leaving LATCH
    always_ff @(posedge clk) begin
        if (!res) begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_addr_q  <= 4'h0;
            frame_data_q  <= 8'h00;
            for (int i = 0; i < 8; i++) digit_q[i] <= 8'h00;
            decode_q      <= 8'h00;
            intensity_q   <= 4'h0;
            scan_q        <= 3'd0;
            shutdown_q    <= 1'b0;
            test_q        <= 1'b0;
        end else begin
            frame_valid_q <= (state_q == LATCH);
            frame_err_q   <= err_d;
            if (state_q == LATCH) begin
                frame_addr_q <= wr_addr_s;
                frame_data_q <= wr_data_s;
                case (wr_addr_s) inside
                    [ADDR_DIGIT0:ADDR_DIGIT7]: digit_q[3'(wr_addr_s - ADDR_DIGIT0)] <= wr_data_s;
                    ADDR_DECODE:    decode_q    <= wr_data_s;
                    ADDR_INTENSITY: intensity_q <= wr_data_s[3:0];
                    ADDR_SCANLIM:   scan_q      <= wr_data_s[2:0];
                    ADDR_SHUTDOWN:  shutdown_q  <= wr_data_s[0];
                    ADDR_TEST:      test_q      <= wr_data_s[0];
                    default: ;
                endcase
            end
        end
    end

    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;
    assign frame_addr   = frame_addr_q;
    assign frame_data   = frame_data_q;
    assign rd_data      = digit_q[rd_sel];
    assign decode_mode  = decode_q;
    assign intensity    = intensity_q;
    assign scan_limit   = scan_q;
    assign shutdown_n   = shutdown_q;
    assign display_test = test_q;

endmodule

// File: tb/tb_spi_display_receiver.sv
// Scoreboard bench: stimulus pushes expected frame events, a monitor pops them on each DUT pulse.
module tb_spi_display_receiver;

    logic       clk = 1'b0;
    logic       res;
    logic [2:0] rd_sel;
    logic       frame_valid, frame_err, shutdown_n, display_test;
    logic [3:0] frame_addr, intensity;
    logic [7:0] frame_data, rd_data, decode_mode;
    logic [2:0] scan_limit;

    spi_display_receiver_if spi ();

    spi_display_receiver dut (
        .clk(clk), .res(res), .spi(spi),
        .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_data(frame_data),
        .frame_err(frame_err), .rd_sel(rd_sel), .rd_data(rd_data),
        .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
        .shutdown_n(shutdown_n), .display_test(display_test));

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] dec;
        logic [3:0] inten;
        logic [2:0] scan;
        logic       sd;
        logic       tst;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    int         vectors = 0;
    int         miscompares = 0;

    // Reference register file
    logic [7:0] m_dig [8];
    logic [7:0] m_dec;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_sd, m_tst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
        m_dec = 8'h00; m_int = 4'h0; m_scan = 3'd0; m_sd = 1'b0; m_tst = 1'b0;
    endfunction

    // An n-bit frame keeps its last 16 bits; anything shorter is an error
    function automatic void model_frame(input logic [31:0] val, input int n);
        exp_t e;
        logic [15:0] f;
        e.is_err = (n < 16);
        f = val[15:0];
        e.addr = f[11:8];
        e.data = f[7:0];
        if (!e.is_err) begin
            if (e.addr >= 4'd1 && e.addr <= 4'd8) m_dig[e.addr - 4'd1] = e.data;
            else if (e.addr == 4'd9)  m_dec  = e.data;
            else if (e.addr == 4'd10) m_int  = e.data[3:0];
            else if (e.addr == 4'd11) m_scan = e.data[2:0];
            else if (e.addr == 4'd12) m_sd   = e.data[0];
            else if (e.addr == 4'd15) m_tst  = e.data[0];
        end
        e.dec = m_dec; e.inten = m_int; e.scan = m_scan; e.sd = m_sd; e.tst = m_tst;
        exp_q.push_back(e);
    endfunction

    // Monitor: every pulse must match the oldest expected event
    always @(negedge clk) begin
        if (frame_valid || frame_err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_valid", frame_valid, !mon_e.is_err);
                chk("pulse_err", frame_err, mon_e.is_err);
                if (!mon_e.is_err) begin
                    chk("frame_addr", frame_addr, mon_e.addr);
                    chk("frame_data", frame_data, mon_e.data);
                end
                chk("decode_mode", decode_mode, mon_e.dec);
                chk("intensity", intensity, mon_e.inten);
                chk("scan_limit", scan_limit, mon_e.scan);
                chk("shutdown_n", shutdown_n, mon_e.sd);
                chk("display_test", display_test, mon_e.tst);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n);
        spi.spi_cs = 1'b0;
        clks(4);
        for (int i = n - 1; i >= 0; i--) begin
            spi.spi_mosi = val[i];
            clks(4);
            spi.spi_sck = 1'b1;
            clks(4);
            spi.spi_sck = 1'b0;
        end
        clks(4);
    endtask

    task automatic send_frame(input logic [31:0] val, input int n);
        shift_bits(val, n);
        model_frame(val, n);
        spi.spi_cs = 1'b1;
        clks(10);
        chk("pulse_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        res = 1'b0;
        spi.spi_cs = 1'b1; spi.spi_sck = 1'b0; spi.spi_mosi = 1'b0;
        clks(4);
        res = 1'b1;
        model_reset();
        clks(2);
    endtask

    task automatic check_regs();
        @(negedge clk);
        chk("reg_decode", decode_mode, m_dec);
        chk("reg_intensity", intensity, m_int);
        chk("reg_scan", scan_limit, m_scan);
        chk("reg_shutdown", shutdown_n, m_sd);
        chk("reg_test", display_test, m_tst);
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            chk("rd_data", rd_data, m_dig[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lens [8];
        lens = '{8, 12, 15, 16, 16, 16, 17, 24};
        rd_sel = 3'd0;
        do_reset();

        @(negedge clk);
        chk("rst_valid", frame_valid, 32'd0);
        chk("rst_err", frame_err, 32'd0);
        chk("rst_addr", frame_addr, 32'd0);
        chk("rst_data", frame_data, 32'd0);
        check_regs();

        send_frame(32'h0C01, 16);
        check_regs();
        send_frame(32'h0105, 16);
        send_frame(32'h0809, 16);
        check_regs();
        send_frame(32'h0A3FF, 10);
        check_regs();
        send_frame(32'hAB0A07, 24);
        check_regs();

        shift_bits(32'h0B, 8);
        do_reset();
        send_frame(32'h0902, 16);
        check_regs();

        for (int d = 1; d <= 6; d++) begin
            send_frame({16'h0, 8'(d), 8'(d)}, 16);
            for (int k = 0; k < 3; k++) begin
                spi.spi_sck = 1'b1; clks(4);
                spi.spi_sck = 1'b0; clks(4);
            end
        end
        send_frame(32'h0F01, 16);
        check_regs();

        for (int r = 0; r < 20; r++) begin
            send_frame($urandom, lens[$urandom_range(0, 7)]);
            check_regs();
        end

        clks(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_display_receiver.md
Name: spi_display_receiver

Overview:
SPI receiver (CPOL=0, CPHA=0, MSB first) for the 16-bit MAX7219-style frames that the stopwatch display driver emits on Mosi/Cs/Clk_SPI.
- Oversamples the three SPI lines with the system clock and decodes address/data.
- Holds a shadow copy of the display register file (8 digit registers plus control registers).
- Used as an on-chip loopback/monitor and as the bench-side model for checking the display path.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each SPI input before edge detection (≥2)
FRAME_BITS, 16, bits per valid frame; address = bits[11:8], data = bits[7:0], bits[15:12] ignored

Ports:
clk  in  1  system clock (1 MHz in the stopwatch)
res  in  1  reset; synchronous, active-low
spi_mosi  in  1  serial data, asynchronous to clk
spi_cs  in  1  chip select, active low, asynchronous to clk
spi_sck  in  1  serial clock, asynchronous to clk
frame_valid  out  1  one-cycle pulse: a frame was latched
frame_addr  out  4  address of the last latched frame
frame_data  out  8  data of the last latched frame
frame_err  out  1  one-cycle pulse: Cs rose with fewer than FRAME_BITS bits
rd_sel  in  3  digit register select (0 = digit 0 … 7 = digit 7)
rd_data  out  8  combinational read of the selected digit register
decode_mode  out  8  register 0x9
intensity  out  4  register 0xA, low nibble
scan_limit  out  3  register 0xB, low 3 bits
shutdown_n  out  1  register 0xC, bit 0 (0 = shutdown)
display_test  out  1  register 0xF, bit 0

Behaviour:
- Reset (res=0 at a clk edge):
  - all synchronizers = idle levels (cs=1, sck=0, mosi=0); state = IDLE; bit counter = 0; shift register = 0.
  - frame_valid = 0, frame_err = 0, frame_addr = 0, frame_data = 0.
  - digit registers = 0x00; decode_mode = 0x00; intensity = 0; scan_limit = 0; shutdown_n = 0; display_test = 0.
  - Reset mid-frame discards the partial frame with no pulse.
- Synchronization: each input passes through SYNC_STAGES FFs plus one history FF. sck_rise = synced sck 0→1. cs_fall / cs_rise = synced cs edges.
- SPI timing requirement on the pins: each SCK and CS level must be held ≥3 clk periods. Faster input is out of spec; no behaviour is guaranteed.
- State machine:
  - IDLE: on cs_fall → SHIFT, bit counter = 0. SCK edges in IDLE are ignored.
  - SHIFT, on sck_rise: shift register = {shift[14:0], synced mosi}; bit counter increments, saturating at 31.
  - SHIFT, on cs_rise: → LATCH if count ≥ FRAME_BITS, else → IDLE with frame_err = 1 for one cycle.
  - sck_rise and cs_rise in the same cycle: the shift happens first, then the count is evaluated including that bit.
  - LATCH (one cycle): frame_valid = 1; frame_addr/frame_data load from the shift register. This keeps the last 16 bits shifted, so overlong frames are accepted MAX7219-style. Register write happens in this cycle; → IDLE.
- Latency: frame_valid rises SYNC_STAGES+2 clk edges after the pin-level Cs rise is sampled. Register outputs update on the same edge as frame_valid.
- Register write decode on frame_addr:
  - 0x0: no-op, frame_valid still pulses.
  - 0x1–0x8: digit[addr-1] = data.
  - 0x9 / 0xA / 0xB / 0xC / 0xF: as listed under Ports.
  - 0xD, 0xE: no-op.
- rd_data = digit[rd_sel], combinational, no latency. A write visible in cycle N is readable in cycle N+1.
- cs_fall while in LATCH is not possible: Cs hold ≥3 cycles.

Decomposition:
- Shared package (display_pkg) holds:
  - address constants ADDR_NOOP=0x0, ADDR_DIGIT0=0x1, ADDR_DECODE=0x9, ADDR_INTENSITY=0xA, ADDR_SCANLIM=0xB, ADDR_SHUTDOWN=0xC, ADDR_TEST=0xF;
  - FRAME_BITS;
  - state encoding IDLE/SHIFT/LATCH.
- One sub-module, spi_input_sync: parameterised synchronizer plus edge detector, instantiated three times (cs, sck, mosi; mosi uses the level only).

Test Plan:
1. Reset, then frame 0x0C01 (Cs low, 16 SCK at 8-clk period) → one frame_valid, frame_addr=0xC, frame_data=0x01, shutdown_n=1, no frame_err.
2. Frames 0x0105 then 0x0809; rd_sel=0 → rd_data=0x05; rd_sel=7 → 0x09; others 0x00.
3. Short frame: 10 bits then Cs high → frame_err pulses once, frame_valid stays 0, all registers unchanged.
4. Overlong frame: 24 bits 0xAB_0A07 → frame_valid, addr=0xA, data=0x07, intensity=7.
5. res=0 after 8 bits of 0x0B05, released, full frame 0x0902 → only one frame_valid, decode_mode=0x02, scan_limit=0.
6. Full sequence of six digit writes 0x0101..0x0606 plus 0x0F01 → digits 1..6 readable, display_test=1; SCK edges with Cs high in between produce no pulses.
